alu_muldiv: RTL

Parametrised, handshaked execution unit for the MIPS datapath. It keeps the single-cycle integer operations and their existing op encodings, and adds iterative signed/unsigned multiply and divide. Multiply and divide results go to architectural HI/LO registers, readable through MFHI/MFLO. The unit sits in the EX stage; the pipeline stalls on `in_ready` low while a multiply or divide is in progress.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/muldiv_iter.sv | 119 +++++++++++
 rtl/alu_muldiv.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU with iterative multiply/divide:
// op codes, mul/div sequencer states and op-class decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_UNDEF = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine. Works on
// operand magnitudes for WIDTH steps, then applies the sign fix in FIX.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    md_state_e        r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    // r_hi: product high half / partial remainder; r_lo: multiplier / quotient
    logic [WIDTH-1:0] r_hi, r_lo, r_mb, r_a;
    logic             r_is_div, r_neg_q, r_neg_r, r_div0;

    logic [WIDTH-1:0]   w_ma, w_mb, w_step_hi, w_step_lo, w_q, w_r;
    logic [WIDTH:0]     w_madd, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_f;

    assign w_ma = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mb = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // One multiply or divide step on the current accumulator pair
    always_comb begin
        w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_mb};
        if (r_is_div) begin
            // borrow out means the trial subtraction failed: keep the shifted remainder
            w_step_hi = w_diff[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_diff[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
        end else begin
            w_step_hi = w_madd[WIDTH:1];
            w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and special cases presented during FIX
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_f = r_neg_q ? -w_prod : w_prod;
        w_q      = r_neg_q ? -r_lo : r_lo;
        w_r      = r_neg_r ? -r_hi : r_hi;
        if (!r_is_div) begin
            o_hi = w_prod_f[2*WIDTH-1:WIDTH];
            o_lo = w_prod_f[WIDTH-1:0];
        end else if (r_div0) begin
            o_hi = r_a;
            o_lo = '1;
        end else begin
            o_hi = w_r;
            o_lo = w_q;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: flush beats everything, RUN lasts WIDTH steps
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (i_flush) w_next = ST_IDLE;
    end

    // Operand capture at start, one iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mb     <= '0;
            r_a      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (r_state == ST_IDLE && i_start && !i_flush) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_ma;
            r_mb     <= w_mb;
            r_a      <= i_a;
            r_is_div <= i_is_div;
            r_neg_q  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_signed && i_a[WIDTH-1];
            r_div0   <= (i_b == '0);
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_FIX) && !i_flush;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage execution unit: single-cycle ALU, valid/ready handshake,
// architectural HI/LO and registered result/flags.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             positive,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] r_result, r_hi, r_lo;
    logic             r_out_valid, r_zero, r_pos;

    logic             w_accept, w_is_md, w_start, w_busy, w_done, w_wr;
    logic [WIDTH-1:0] w_alu, w_md_hi, w_md_lo, w_wr_data;

    assign w_is_md  = is_muldiv(op);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_start  = w_accept && w_is_md;

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_signed (md_is_signed(op)),
        .i_is_div (md_is_div(op)),
        .i_a      (a),
        .i_b      (b),
        .i_flush  (flush),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    // Single-cycle operations; undefined codes yield zero
    always_comb begin
        w_alu = '0;
        case (op)
            OP_NOP:  w_alu = a;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  w_alu = ~(a | b);
            OP_MFLO: w_alu = r_lo;
            OP_MFHI: w_alu = r_hi;
            default: w_alu = '0;
        endcase
    end

    // Completion and acceptance are exclusive (no accept while busy)
    assign w_wr      = w_done || (w_accept && !w_is_md);
    assign w_wr_data = w_done ? w_md_lo : w_alu;

    // Result/flag registers and architectural HI/LO; flags are captured with
    // the result so every output reads zero straight out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_pos       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= w_wr;
            if (w_wr) begin
                r_result <= w_wr_data;
                r_zero   <= ~|w_wr_data;
                r_pos    <= ~w_wr_data[WIDTH-1] && (|w_wr_data);
            end
            if (w_done) begin
                r_hi <= w_md_hi;
                r_lo <= w_md_lo;
            end
        end
    end

    assign in_ready  = !w_busy;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign positive  = r_pos;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
